relax_osc_meas_ctrl: RTL and testbench



---
 rtl/relax_osc_pkg.sv | 16 +
 rtl/osc_edge_sync.sv | 24 ++
 rtl/relax_osc_meas_ctrl.sv | 149 ++++++++++++++
 tb/tb_relax_osc_meas_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/relax_osc_pkg.sv
// rtl/relax_osc_pkg.sv - shared state encoding and default parameters for the oscillator meter
package relax_osc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } meas_state_t;

    localparam int DEF_GATE_W        = 16;
    localparam int DEF_CNT_W         = 16;
    localparam int DEF_SETTLE_CYCLES = 256;
    localparam int DEF_WDOG_CYCLES   = 1024;

endpackage

// File: rtl/osc_edge_sync.sv
// rtl/osc_edge_sync.sv - two-flop synchronizer plus history flop producing a rising-edge pulse
module osc_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic osc_in,
    output logic edge_p
);

    logic [1:0] r_sync;
    logic       r_hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b00;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], osc_in};
            r_hist <= r_sync[1];
        end
    end

    assign edge_p = r_sync[1] & ~r_hist;

endmodule

// File: rtl/relax_osc_meas_ctrl.sv
// rtl/relax_osc_meas_ctrl.sv - oscillator power-up sequencer and gated edge counter
// Optional no-edge watchdog built when RELAX_OSC_WDOG_EN is defined.
module relax_osc_meas_ctrl
    import relax_osc_pkg::*;
#(
    parameter int GATE_W        = DEF_GATE_W,
    parameter int CNT_W         = DEF_CNT_W,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int WDOG_CYCLES   = DEF_WDOG_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic              osc_in,
    output logic              osc_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              timeout
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);

    meas_state_t       r_state;
    meas_state_t       w_state_nxt;
    logic [SET_W-1:0]  r_settle_cnt;
    logic [GATE_W-1:0] r_gate;
    logic [GATE_W-1:0] r_gate_cnt;
    logic [CNT_W-1:0]  r_edge_cnt;
    logic              r_ovf_acc;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              w_edge_p;
    logic              w_gate_last;
    logic              w_hit;
    logic              w_cnt_sat;
    logic [CNT_W-1:0]  w_edge_cnt_nxt;
    logic              w_ovf_nxt;
    logic              w_wdog_trip;

    osc_edge_sync u_edge_sync (
        .clk    (clk),
        .rst    (rst),
        .osc_in (osc_in),
        .edge_p (w_edge_p)
    );

    assign w_gate_last    = (r_gate_cnt == '0);
    assign w_hit          = (r_state == ST_MEASURE) && w_edge_p;
    assign w_cnt_sat      = (r_edge_cnt == {CNT_W{1'b1}});
    assign w_edge_cnt_nxt = (w_hit && !w_cnt_sat) ? r_edge_cnt + 1'b1 : r_edge_cnt;
    assign w_ovf_nxt      = r_ovf_acc | (w_hit && w_cnt_sat);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_state_nxt = ST_SETTLE;
            ST_SETTLE:  if (r_settle_cnt == '0) w_state_nxt = ST_MEASURE;
            ST_MEASURE: if (w_gate_last || w_wdog_trip) w_state_nxt = ST_DONE;
            ST_DONE:    w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Gate counter is loaded with G-1 so a captured 0 wraps to the full 2^GATE_W window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= '0;
            r_gate       <= '0;
            r_gate_cnt   <= '0;
            r_edge_cnt   <= '0;
            r_ovf_acc    <= 1'b0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_settle_cnt <= SETTLE_LOAD;
                        r_gate       <= gate_cycles;
                    end
                end
                ST_SETTLE: begin
                    if (r_settle_cnt != '0) begin
                        r_settle_cnt <= r_settle_cnt - 1'b1;
                    end else begin
                        r_gate_cnt <= r_gate - 1'b1;
                        r_edge_cnt <= '0;
                        r_ovf_acc  <= 1'b0;
                    end
                end
                ST_MEASURE: begin
                    r_gate_cnt <= r_gate_cnt - 1'b1;
                    r_edge_cnt <= w_edge_cnt_nxt;
                    r_ovf_acc  <= w_ovf_nxt;
                    if (w_state_nxt == ST_DONE) begin
                        r_count    <= w_edge_cnt_nxt;
                        r_overflow <= w_ovf_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef RELAX_OSC_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] r_wdog;
    logic [WDOG_W-1:0] w_wdog_nxt;
    logic              r_timeout;

    assign w_wdog_nxt  = w_edge_p ? '0 : r_wdog + 1'b1;
    // A normal gate expiry in the same cycle wins, so a completed window is never flagged.
    assign w_wdog_trip = (r_state == ST_MEASURE) && !w_gate_last &&
                         (w_wdog_nxt == WDOG_W'(WDOG_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == ST_SETTLE) begin
                r_wdog <= '0;
            end else if (r_state == ST_MEASURE) begin
                r_wdog <= w_wdog_nxt;
                if (w_state_nxt == ST_DONE) r_timeout <= w_wdog_trip;
            end
        end
    end

    assign timeout = r_timeout;
`else
    assign w_wdog_trip = 1'b0;
    assign timeout     = 1'b0;
`endif

    assign osc_en   = (r_state == ST_SETTLE) || (r_state == ST_MEASURE);
    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_relax_osc_meas_ctrl.sv
// tb/tb_relax_osc_meas_ctrl.sv - self-checking bench for relax_osc_meas_ctrl
module tb_relax_osc_meas_ctrl;

    localparam int GATE_W  = 8;
    localparam int CNT_W   = 4;
    localparam int SETTLE  = 4;
    localparam int WDOG    = 20;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [GATE_W-1:0] gate_cycles = '0;
    logic              osc_gen = 1'b0;
    logic              osc_man = 1'b0;
    logic              osc_in;
    logic              osc_en;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              timeout;

    int checks   = 0;
    int failures = 0;
    bit osc_run  = 1'b0;
    int osc_half = 40;

    assign osc_in = osc_gen | osc_man;

    relax_osc_meas_ctrl #(
        .GATE_W        (GATE_W),
        .CNT_W         (CNT_W),
        .SETTLE_CYCLES (SETTLE),
        .WDOG_CYCLES   (WDOG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .gate_cycles (gate_cycles),
        .osc_in      (osc_in),
        .osc_en      (osc_en),
        .busy        (busy),
        .done        (done),
        .count       (count),
        .overflow    (overflow),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    // Oscillator transitions stay at 2 ns past a multiple of 10 ns, clear of both clock edges.
    initial begin
        #2;
        forever begin
            #(osc_half);
            if (osc_run) osc_gen = ~osc_gen;
            else         osc_gen = 1'b0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a measurement is a time window [k, end] measured in clock edges; rising edges of
    // osc_in first sampled at edge e land in cycle e+1 and count when that cycle lies in MEASURE.
    int   n = 0;
    bit   m_act = 1'b0;
    int   m_mstart, m_end, m_g, m_raw, m_run;
    bit   m_tmo;
    bit   osc_prev, rise_d1, rise_d2, rise_now;
    logic e_busy = 1'b0, e_osc_en = 1'b0, e_done = 1'b0, e_ovf = 1'b0, e_tmo = 1'b0;
    logic [CNT_W-1:0] e_count = '0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_act = 1'b0; e_busy = 1'b0; e_osc_en = 1'b0; e_done = 1'b0;
                e_count = '0; e_ovf = 1'b0; e_tmo = 1'b0;
                osc_prev = 1'b0; rise_d1 = 1'b0; rise_d2 = 1'b0;
            end else begin
                n++;
                if (m_act && (n - 1) >= m_mstart && (n - 1) < m_end) begin
                    if (rise_d2) begin
                        m_raw++;
                        m_run = 0;
                    end else begin
                        m_run++;
                    end
`ifdef RELAX_OSC_WDOG_EN
                    if (m_run == WDOG && n != m_mstart + m_g) begin
                        m_end = n;
                        m_tmo = 1'b1;
                    end
`endif
                end
                if (m_act && (n - 1) == m_end) begin
                    m_act = 1'b0;
                end else if (!m_act && start) begin
                    m_act    = 1'b1;
                    m_g      = (gate_cycles == '0) ? (1 << GATE_W) : int'(gate_cycles);
                    m_mstart = n + SETTLE;
                    m_end    = m_mstart + m_g;
                    m_raw    = 0;
                    m_run    = 0;
                    m_tmo    = 1'b0;
                end
                e_busy   = m_act;
                e_done   = m_act && (n == m_end);
                e_osc_en = m_act && (n < m_end);
                if (e_done) begin
                    e_count = (m_raw > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(m_raw);
                    e_ovf   = (m_raw > CNT_MAX);
                    e_tmo   = m_tmo;
                end
                rise_now = osc_in && !osc_prev;
                osc_prev = osc_in;
                rise_d2  = rise_d1;
                rise_d1  = rise_now;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("busy", busy, e_busy);
                check("osc_en", osc_en, e_osc_en);
                check("done", done, e_done);
                check("count", count, e_count);
                check("overflow", overflow, e_ovf);
                check("timeout", timeout, e_tmo);
            end
        end
    end

    // Returns cycles from start acceptance to the done cycle; the caller sits in the done cycle.
    task automatic do_meas(input logic [GATE_W-1:0] g, input int bound, output int lat, output bit ok);
        @(negedge clk);
        start       = 1'b1;
        gate_cycles = g;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        ok    = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int               lat;
        bit               ok;
        int               n_done;
        int               gap;
        logic [CNT_W-1:0] cap;

        repeat (3) @(negedge clk);
        check("rst_osc_en", osc_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_timeout", timeout, 0);
        rst = 1'b0;

        osc_half = 40;
        osc_run  = 1'b1;
        do_meas(8'd100, 400, lat, ok);
        check("nom_done_seen", ok, 1);
        check("nom_latency", lat, 104);
        check("nom_count_12_13", (count >= 4'd12 && count <= 4'd13), 1);
        check("nom_overflow", overflow, 0);
        @(negedge clk);
        check("nom_done_one_cycle", done, 0);

        do_meas(8'd0, 400, lat, ok);
        check("gate0_done_seen", ok, 1);
        check("gate0_latency", lat, SETTLE + 256);

        osc_half = 20;
        do_meas(8'd200, 400, lat, ok);
        check("sat_latency", lat, SETTLE + 200);
        check("sat_count", count, CNT_MAX);
        check("sat_overflow", overflow, 1);
        osc_half = 40;

        osc_run = 1'b0;
        repeat (10) @(negedge clk);
        @(negedge clk);
        start       = 1'b1;
        gate_cycles = 8'd20;
        @(negedge clk);
        start = 1'b0;
        #2 osc_man = 1'b1;
        repeat (6) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        n_done = 0;
        cap    = '1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                cap = count;
            end
        end
        check("busy_start_single_done", n_done, 1);
        check("settle_edge_not_counted", cap, 0);
        osc_man = 1'b0;

        repeat (3) @(negedge clk);
        do_meas(8'd50, 200, lat, ok);
        check("stuck_done_seen", ok, 1);
        check("stuck_count", count, 0);
`ifdef RELAX_OSC_WDOG_EN
        check("stuck_latency", lat, SETTLE + WDOG);
        check("stuck_timeout", timeout, 1);
`else
        check("stuck_latency", lat, SETTLE + 50);
        check("stuck_timeout", timeout, 0);
`endif

        osc_run = 1'b1;
        @(negedge clk);
        start       = 1'b1;
        gate_cycles = 8'd10;
        ok          = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check("b2b_first_done", ok, 1);
        gap = 0;
        ok  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            gap++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check("b2b_second_done", ok, 1);
        check("b2b_gap", gap, SETTLE + 10 + 2);
        repeat (4) @(negedge clk);
        check("b2b_no_third", busy, 0);

        @(negedge clk);
        start       = 1'b1;
        gate_cycles = 8'd100;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_osc_en", osc_en, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        do_meas(8'd100, 400, lat, ok);
        check("post_rst_latency", lat, 104);
        check("post_rst_count_12_13", (count >= 4'd12 && count <= 4'd13), 1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
